// File: rtl/timer_apb_slave.sv
// APB register block for the 8-bit timer: TDR, TCR and W1C TSR.
// Drives counter control fields and latches overflow/underflow events.
module timer_apb_slave #(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [7:0]        pwdata,
  output logic [7:0]        prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [7:0]        tdr_o,
  output logic              load_o,
  output logic              up_dw_o,
  output logic              en_o,
  output logic [1:0]        cks_o,
  input  logic              ovf_set_i,
  input  logic              udf_set_i
);

  localparam logic [2:0] WAIT_CNT = 3'(WAIT_STATES);
  localparam logic [7:0] TCR_MASK = 8'hB3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  wcnt;
  logic [7:0]  tdr;
  logic [7:0]  tcr;
  logic [1:0]  tsr;
  logic [7:0]  rd_mux;
  logic [1:0]  tsr_clr;
  logic [1:0]  tsr_set;
  logic        wait_hit;
  logic        addr_ok;
  logic        sel_tdr;
  logic        sel_tcr;
  logic        sel_tsr;
  logic        wr_en;

  assign wait_hit = (wcnt == WAIT_CNT);
  assign sel_tdr  = (paddr == ADDR_W'(0));
  assign sel_tcr  = (paddr == ADDR_W'(1));
  assign sel_tsr  = (paddr == ADDR_W'(2));
  assign addr_ok  = sel_tdr | sel_tcr | sel_tsr;
  assign wr_en    = pready & pwrite & addr_ok;

  // IDLE doubles as the bus SETUP cycle; ACCESS holds until the wait count is met.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (psel && !penable) state_nx = ACCESS;
      end
      ACCESS: begin
        if (!psel)                             state_nx = IDLE;
        else if (penable && wait_hit)          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pready  = (state == ACCESS) && psel && penable && wait_hit;
    pslverr = pready && !addr_ok;
    prdata  = (pready && !pwrite && addr_ok) ? rd_mux : 8'h00;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset)                              wcnt <= 3'd0;
    else if (state != ACCESS)                wcnt <= 3'd0;
    else if (psel && penable && !wait_hit)   wcnt <= wcnt + 3'd1;
  end

  always_comb begin
    rd_mux = 8'h00;
    unique case (1'b1)
      sel_tdr: rd_mux = tdr;
      sel_tcr: rd_mux = tcr;
      sel_tsr: rd_mux = {6'd0, tsr};
      default: rd_mux = 8'h00;
    endcase
  end

  // Event set dominates a same-cycle W1C of the same bit.
  assign tsr_clr = (wr_en && sel_tsr) ? pwdata[1:0] : 2'b00;
  assign tsr_set = {udf_set_i, ovf_set_i};

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tdr <= 8'h00;
      tcr <= 8'h00;
      tsr <= 2'b00;
    end else begin
      if (wr_en && sel_tdr) tdr <= pwdata;
      if (wr_en && sel_tcr) tcr <= pwdata & TCR_MASK;
      tsr <= (tsr & ~tsr_clr) | tsr_set;
    end
  end

  assign tdr_o   = tdr;
  assign load_o  = tcr[7];
  assign up_dw_o = tcr[5];
  assign en_o    = tcr[4];
  assign cks_o   = tcr[1:0];

endmodule

// File: tb/tb_timer_apb_slave.sv
// Randomized bench for timer_apb_slave (0 and 3 wait states)
// checked against a register-level reference model.
module tb_timer_apb_slave;

  logic       pclk = 0;
  logic       preset;
  logic       psel0, psel3, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic       ovf, udf;

  logic [7:0] prdata0, prdata3, tdr0, tdr3;
  logic       pready0, pready3, err0, err3;
  logic       ld0, ld3, ud0, ud3, en0, en3;
  logic [1:0] ck0, ck3;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_tdr [2];
  logic [7:0] m_tcr [2];
  logic [1:0] m_tsr [2];

  always #5 pclk = ~pclk;

  timer_apb_slave #(.WAIT_STATES(0), .ADDR_W(8)) dut0 (
    .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata0),
    .pready(pready0), .pslverr(err0), .tdr_o(tdr0), .load_o(ld0),
    .up_dw_o(ud0), .en_o(en0), .cks_o(ck0),
    .ovf_set_i(ovf), .udf_set_i(udf)
  );

  timer_apb_slave #(.WAIT_STATES(3), .ADDR_W(8)) dut3 (
    .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata3),
    .pready(pready3), .pslverr(err3), .tdr_o(tdr3), .load_o(ld3),
    .up_dw_o(ud3), .en_o(en3), .cks_o(ck3),
    .ovf_set_i(ovf), .udf_set_i(udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int di);
    return di == 0 ? pready0 : pready3;
  endfunction

  function automatic logic [7:0] rd(input int di);
    return di == 0 ? prdata0 : prdata3;
  endfunction

  function automatic logic err(input int di);
    return di == 0 ? err0 : err3;
  endfunction

  function automatic logic [7:0] mreg(input int di, input logic [7:0] a);
    if (a == 0) return m_tdr[di];
    if (a == 1) return m_tcr[di];
    if (a == 2) return {6'd0, m_tsr[di]};
    return 8'h00;
  endfunction

  function automatic logic [12:0] outs(input int di);
    if (di == 0) return {tdr0, ld0, ud0, en0, ck0};
    return {tdr3, ld3, ud3, en3, ck3};
  endfunction

  function automatic logic [12:0] m_outs(input int di);
    logic [7:0] c;
    c = m_tcr[di];
    return {m_tdr[di], c[7], c[5], c[4], c[1:0]};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_tdr[i] = 0; m_tcr[i] = 0; m_tsr[i] = 0;
    end
  endtask

  task automatic chk_outs(input int di);
    chk(di == 0 ? "outs_w0" : "outs_w3", 32'(outs(di)), 32'(m_outs(di)));
  endtask

  task automatic xfer(input int di, input bit wr, input logic [7:0] a,
                      input logic [7:0] d, input logic [1:0] sets);
    logic [7:0] exp_rd;
    int cyc;
    bit got;
    exp_rd = (!wr && a < 3) ? mreg(di, a) : 8'h00;
    @(posedge pclk); #1;
    psel0 = (di == 0); psel3 = (di == 1);
    penable = 0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge pclk);
    chk("setup_rdy", 32'(rdy(di)), 0);
    chk("setup_rd", 32'(rd(di)), 0);
    @(posedge pclk); #1;
    penable = 1;
    cyc = 0; got = 0;
    while (!got && cyc <= 20) begin
      @(negedge pclk);
      if (rdy(di)) begin
        got = 1;
        chk("latency", cyc, di == 0 ? 0 : 3);
        chk("rdata", 32'(rd(di)), 32'(exp_rd));
        chk("slverr", 32'(err(di)), 32'(a > 2));
        ovf = sets[0]; udf = sets[1];
      end else begin
        cyc++;
        @(posedge pclk); #1;
      end
    end
    if (!got) chk("timeout", 0, 1);
    @(posedge pclk); #1;
    psel0 = 0; psel3 = 0; penable = 0; ovf = 0; udf = 0;
    if (got) begin
      if (wr && a == 0) m_tdr[di] = d;
      if (wr && a == 1) m_tcr[di] = d & 8'hB3;
      if (wr && a == 2) m_tsr[di] = m_tsr[di] & ~d[1:0];
      for (int i = 0; i < 2; i++) m_tsr[i] = m_tsr[i] | sets;
    end
  endtask

  task automatic pulse(input logic [1:0] sets);
    @(posedge pclk); #1;
    ovf = sets[0]; udf = sets[1];
    @(posedge pclk); #1;
    ovf = 0; udf = 0;
    for (int i = 0; i < 2; i++) m_tsr[i] = m_tsr[i] | sets;
  endtask

  initial begin
    preset = 1; psel0 = 0; psel3 = 0; penable = 0; pwrite = 0;
    paddr = 0; pwdata = 0; ovf = 0; udf = 0;
    m_reset();
    repeat (2) @(posedge pclk);
    #2 preset = 0;
    #1;
    chk("rst_rdy0", 32'(pready0), 0);
    chk_outs(0);
    chk_outs(1);

    xfer(0, 1, 8'h00, 8'hA5, 2'b00);
    chk("tdr_o_a5", 32'(tdr0), 32'hA5);
    xfer(0, 0, 8'h00, 8'h00, 2'b00);
    xfer(0, 1, 8'h01, 8'hFF, 2'b00);
    xfer(0, 0, 8'h01, 8'h00, 2'b00);
    chk("tcr_ff_outs", 32'(outs(0) & 13'h1F), 32'h1F);
    xfer(0, 1, 8'h01, 8'h33, 2'b00);
    xfer(0, 0, 8'h01, 8'h00, 2'b00);
    chk_outs(0);

    pulse(2'b10);
    xfer(0, 0, 8'h02, 8'h00, 2'b00);
    xfer(0, 1, 8'h02, 8'h01, 2'b00);
    xfer(0, 0, 8'h02, 8'h00, 2'b00);
    xfer(0, 1, 8'h02, 8'h02, 2'b00);
    xfer(0, 0, 8'h02, 8'h00, 2'b00);
    chk("tsr_cleared", 32'(m_tsr[0]), 0);
    xfer(0, 1, 8'h02, 8'h03, 2'b10);
    xfer(0, 0, 8'h02, 8'h00, 2'b00);
    chk("tsr_set_wins", 32'(m_tsr[0]), 2);

    xfer(1, 1, 8'h00, 8'h3C, 2'b00);
    xfer(1, 0, 8'h00, 8'h00, 2'b00);
    xfer(1, 1, 8'h05, 8'h77, 2'b00);
    xfer(1, 0, 8'h05, 8'h00, 2'b00);
    chk_outs(1);

    // asynchronous reset asserted between clock edges
    @(posedge pclk); #3;
    preset = 1;
    #1;
    m_reset();
    chk("amid_rdy0", 32'(pready0), 0);
    chk("amid_rdy3", 32'(pready3), 0);
    chk_outs(0);
    chk_outs(1);
    @(negedge pclk); preset = 0;
    xfer(0, 0, 8'h00, 8'h00, 2'b00);
    xfer(0, 0, 8'h02, 8'h00, 2'b00);

    // reset lands inside a wait-stated write
    @(posedge pclk); #1;
    psel3 = 1; pwrite = 1; paddr = 0; pwdata = 8'h5A; penable = 0;
    @(posedge pclk); #1 penable = 1;
    @(posedge pclk); #1 preset = 1;
    #2 chk("rst_acc_rdy", 32'(pready3), 0);
    @(negedge pclk);
    preset = 0; psel3 = 0; penable = 0;
    m_reset();
    xfer(1, 0, 8'h00, 8'h00, 2'b00);
    xfer(1, 1, 8'h00, 8'h11, 2'b00);
    xfer(1, 0, 8'h00, 8'h00, 2'b00);

    // penable without a setup phase
    @(posedge pclk); #1;
    psel0 = 1; penable = 1; pwrite = 1; paddr = 0; pwdata = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("no_setup_rdy", 32'(pready0), 0);
    end
    @(posedge pclk); #1 psel0 = 0; penable = 0;
    chk_outs(0);

    // psel dropped mid-access
    @(posedge pclk); #1;
    psel3 = 1; pwrite = 1; paddr = 1; pwdata = 8'hFF; penable = 0;
    @(posedge pclk); #1 penable = 1;
    @(posedge pclk); #1 psel3 = 0; penable = 0;
    @(negedge pclk);
    chk("abort_rdy", 32'(pready3), 0);
    chk_outs(1);
    xfer(1, 0, 8'h01, 8'h00, 2'b00);

    for (int i = 0; i < 60; i++) begin
      int di;
      logic [1:0] s;
      di = ($urandom % 4 == 0) ? 1 : 0;
      s = ($urandom % 3 == 0) ? 2'($urandom % 4) : 2'b00;
      xfer(di, 1'($urandom % 2), 8'($urandom % 5), 8'($urandom), s);
      if ($urandom % 8 == 0) pulse(2'($urandom % 4));
      chk_outs(di);
    end
    xfer(0, 0, 8'h02, 8'h00, 2'b00);
    xfer(1, 0, 8'h02, 8'h00, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
